load_store_unit: RTL and testbench
==================================

# load_store_unit

Bus initiator that sits between the MIPS datapath and the word-addressed `data_memory`. It accepts byte-addressed load/store requests of byte, halfword or word size, translates them into word accesses, and performs read-modify-write for sub-word stores. It returns sign- or zero-extended load data through a valid/ready response channel, and flags misaligned or out-of-range requests without touching memory.

## Interface
- `MEM_WORDS`, 64: number of 32-bit words in the attached memory. Valid word indices are 0..MEM_WORDS-1.
- `clk` in 1: the single clock. Memory writes and all state updates occur on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: the unit can accept a request. It is 1 only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word. Code 11 is illegal.
- `req_signed` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: the consumer accepts the response.
- `resp_rdata` out 32: extended load data. It is 0 for stores and for errors.
- `resp_err` out 1: the request was misaligned, out of range, or used an illegal size.
- `mem_a` out 32: word index, equal to `addr[31:2]` zero-extended.
- `mem_we` out 1: memory write enable.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory read data. It is combinational from `mem_a`.

## Operation
- **States:** IDLE, ACCESS, WRITE, RESP.
- **IDLE:**
  - A handshake occurs when `req_valid` and `req_ready` are both 1. On handshake the unit latches addr, size, signed, we and wdata.
  - Error condition: size = 11, or halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0, or `addr[31:2]` ≥ MEM_WORDS.
  - On error: set err, go to RESP.
  - Otherwise go to ACCESS.
- **ACCESS:** `mem_a` = latched word index.
  - Load: extract the lane from `mem_rd`, extend it, register the result into `resp_rdata`, go to RESP.
  - Word store: `mem_we`=1, `mem_wd`=wdata, go to RESP.
  - Byte or halfword store: register the merge of `mem_rd` with the wdata lane, go to WRITE.
- **WRITE:** `mem_we`=1, `mem_wd`=merged word, go to RESP.
- **RESP:** `resp_valid`=1. Hold `resp_valid`, `resp_rdata` and `resp_err` stable until `resp_ready`=1, then go to IDLE.
- **Lanes (little-endian):**
  - Byte k occupies bits [8k+7:8k], with k = `addr[1:0]`.
  - The halfword occupies bits [31:16] if `addr[1]` = 1, else bits [15:0].
  - Store data is taken from `wdata[7:0]` for a byte store and `wdata[15:0]` for a halfword store.
- **Write enable:** `mem_we` is decoded combinationally from state. It is never 1 outside ACCESS (word store) or WRITE.
- **No pipelining:** a new request is accepted only in IDLE, so at most one request is outstanding.
- **Output hold:** `mem_a` holds its last value between requests. `mem_wd` is 0 whenever `mem_we`=0.

## Timing
- All outputs are registered or decoded from state. There is no combinational path from `req_*` or `resp_ready` to any output.
- Take T as the handshake edge, with `resp_ready` held at 1:
  - Load: `resp_valid` rises after edge T+1.
  - Word store: `resp_valid` rises after edge T+1; the memory write happens at edge T+1.
  - Sub-word store: `resp_valid` rises after edge T+2; the write happens at edge T+2.
  - Error: `resp_valid` rises after edge T.
- Throughput with `resp_ready`=1 is one request per 3 cycles for loads and word stores, and per 4 cycles for sub-word stores.
- **Reset values:** state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_a`=0, `mem_we`=0, `mem_wd`=0.
- **Reset mid-operation:** asserting `reset` in ACCESS or WRITE drops `mem_we` immediately. If reset is asserted before the clock edge, no write occurs, and any pending response is discarded.
- **Backpressure:** holding `resp_ready`=0 stalls the unit in RESP indefinitely. Memory is not accessed during the stall.

## Structure
- Package `lsu_pkg` holds:
  - size encodings `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10;
  - the state enum (IDLE, ACCESS, WRITE, RESP);
  - the default `MEM_WORDS` constant.
- Sub-module `lsu_lane`, purely combinational, provides:
  - `extract` (rd, offset, size, signed → 32-bit result);
  - `merge` (rd, wdata, offset, size → 32-bit result).
- The FSM, request latches and handshake logic live in `load_store_unit`.

## Test plan
- **Word store, then load:** store addr 0x10, data 0xDEADBEEF.
  - Required: `mem_we` pulse with `mem_a`=4, `mem_wd`=0xDEADBEEF, `resp_err`=0.
  - Then load word from 0x10 returns 0xDEADBEEF two cycles after the handshake.
- **Byte load, signed vs unsigned:** memory word 4 = 0x8180_7F01.
  - Signed byte load at 0x13 → 0xFFFFFF81.
  - Unsigned byte load at 0x13 → 0x00000081.
  - Signed byte load at 0x11 → 0x0000007F.
- **Sub-word store read-modify-write:** word 4 = 0x11223344.
  - Halfword store 0xABCD at 0x12 → word becomes 0xABCD3344, written at T+2.
  - Byte store 0xEE at 0x10 → word becomes 0xABCD33EE.
- **Errors:** halfword at 0x11, word at 0x12, and word at 0x100 (index 64) each return `resp_err`=1 and `resp_rdata`=0 one cycle after the handshake. `mem_we` never pulses.
- **Backpressure and reset:** hold `resp_ready`=0 for 5 cycles.
  - Required: response is stable and `req_ready`=0 throughout.
  - Assert `reset` during the WRITE state of a byte store → memory is unchanged, all outputs are at reset values, and `req_ready`=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default memory depth.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int MEM_WORDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and word-memory signals of the load/store unit.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid and its payload stay stable until that edge, and ready never depends on valid.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_a, mem_we, mem_wd
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: pulls a sign/zero-extended byte or halfword out of
// a memory word, and merges store data into a word for read-modify-write.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rd_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] lane;

    always_comb begin
        shamt = '0;
        mask  = '1;
        case (size_i)
            SZ_BYTE: begin
                shamt = {offset_i, 3'b000};
                mask  = 32'h0000_00FF;
            end
            SZ_HALF: begin
                shamt = {offset_i[1], 4'b0000};
                mask  = 32'h0000_FFFF;
            end
            default: begin
                shamt = '0;
                mask  = '1;
            end
        endcase

        lane      = (rd_i >> shamt) & mask;
        extract_o = lane;
        if (signed_i && (size_i == SZ_BYTE) && lane[7]) begin
            extract_o = lane | 32'hFFFF_FF00;
        end
        if (signed_i && (size_i == SZ_HALF) && lane[15]) begin
            extract_o = lane | 32'hFFFF_0000;
        end

        merge_o = (rd_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed memory: one request
// at a time, read-modify-write for sub-word stores, errors never touch memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.master  lsu_bus,
    output lsu_state_e         dbg_state_o
);

    lsu_state_e  state_q,  state_d;
    logic [1:0]  off_q,    off_d;
    logic [1:0]  size_q,   size_d;
    logic        signed_q, signed_d;
    logic        we_q,     we_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;
    logic [31:0] mem_a_q,  mem_a_d;

    logic [31:0] extract_w;
    logic [31:0] merge_w;
    logic        req_err;
    logic        mem_we_w;

    lsu_lane u_lane (
        .rd_i      (lsu_bus.mem_rd),
        .wdata_i   (wdata_q),
        .offset_i  (off_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .extract_o (extract_w),
        .merge_o   (merge_w)
    );

    assign req_err = (lsu_bus.req_size == 2'b11)
                  || ((lsu_bus.req_size == SZ_HALF) && lsu_bus.req_addr[0])
                  || ((lsu_bus.req_size == SZ_WORD) && (lsu_bus.req_addr[1:0] != 2'b00))
                  || ({2'b00, lsu_bus.req_addr[31:2]} >= 32'(MEM_WORDS));

    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        size_d   = size_q;
        signed_d = signed_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_a_d  = mem_a_q;
        case (state_q)
            IDLE: begin
                if (lsu_bus.req_valid) begin
                    off_d    = lsu_bus.req_addr[1:0];
                    size_d   = lsu_bus.req_size;
                    signed_d = lsu_bus.req_signed;
                    we_d     = lsu_bus.req_we;
                    wdata_d  = lsu_bus.req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        // mem_a only moves for requests that will really access memory
                        mem_a_d = {2'b00, lsu_bus.req_addr[31:2]};
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = extract_w;
                    state_d = RESP;
                end else if (size_q == SZ_WORD) begin
                    state_d = RESP;
                end else begin
                    merged_d = merge_w;
                    state_d  = WRITE;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (lsu_bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            off_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mem_a_q  <= '0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mem_a_q  <= mem_a_d;
        end
    end

    // Decoded from state only, so an async reset drops the write at once.
    assign mem_we_w = ((state_q == ACCESS) && we_q && (size_q == SZ_WORD)) || (state_q == WRITE);

    assign lsu_bus.req_ready  = (state_q == IDLE);
    assign lsu_bus.resp_valid = (state_q == RESP);
    assign lsu_bus.resp_rdata = rdata_q;
    assign lsu_bus.resp_err   = err_q;
    assign lsu_bus.mem_a      = mem_a_q;
    assign lsu_bus.mem_we     = mem_we_w;
    assign lsu_bus.mem_wd     = !mem_we_w ? 32'h0 : ((state_q == WRITE) ? merged_q : wdata_q);
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural memory/response model, per-cycle
// expected-output queue, directed cases followed by random traffic.
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  lsu_state_e dbg_state;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .lsu_bus     (bus),
    .dbg_state_o (dbg_state)
  );

  // attached word memory, written by the DUT
  logic [31:0] mem [64];
  assign bus.mem_rd = (bus.mem_a < 32'd64) ? mem[bus.mem_a[5:0]] : 32'h0;
  always @(posedge clk) begin
    if (bus.mem_we && (bus.mem_a < 32'd64)) mem[bus.mem_a[5:0]] <= bus.mem_wd;
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        rdy;
    logic        rv;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] last_mem_a;
  logic [31:0] last_rdata;
  logic        last_err;
  bit          cmp_en;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sg);
    logic [7:0]  b [4];
    logic [31:0] v;
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    if (sz == SZ_BYTE) begin
      v = 32'(b[off]);
      if (sg && v > 32'd127) v = v - 32'd256;
    end else if (sz == SZ_HALF) begin
      v = off[1] ? 32'({b[3], b[2]}) : 32'({b[1], b[0]});
      if (sg && v > 32'd32767) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] sz);
    logic [7:0] b [4];
    int base;
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    if (sz == SZ_BYTE) begin
      b[off] = wd[7:0];
    end else if (sz == SZ_HALF) begin
      base = off[1] ? 2 : 0;
      b[base]     = wd[7:0];
      b[base + 1] = wd[15:8];
    end else begin
      return wd;
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic bit m_err(input logic [31:0] addr, input logic [1:0] sz);
    return (sz == 2'b11) || (sz == SZ_HALF && addr % 2 != 0)
        || (sz == SZ_WORD && addr % 4 != 0) || (addr / 4 >= 64);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{rdy: 1'b1, rv: 1'b0, we: 1'b0, a: last_mem_a, wd: 32'h0, rdata: 32'h0, err: 1'b0};
      chk("req_ready",  32'(bus.req_ready),  32'(e.rdy));
      chk("resp_valid", 32'(bus.resp_valid), 32'(e.rv));
      chk("mem_we",     32'(bus.mem_we),     32'(e.we));
      chk("mem_a",      bus.mem_a,           e.a);
      chk("mem_wd",     bus.mem_wd,          e.wd);
      if (e.rv) begin
        chk("resp_rdata", bus.resp_rdata,      e.rdata);
        chk("resp_err",   32'(bus.resp_err),   32'(e.err));
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int bp);
    exp_t        e;
    bit          err;
    int          lat;
    logic [31:0] idx, rdata, merged;
    err   = m_err(addr, sz);
    idx   = addr >> 2;
    rdata = 32'h0;
    lat   = 0;
    e = '{rdy: 1'b1, rv: 1'b0, we: 1'b0, a: last_mem_a, wd: 32'h0, rdata: 32'h0, err: 1'b0};
    exp_q.push_back(e);
    if (!err) begin
      last_mem_a = idx;
      e = '{rdy: 1'b0, rv: 1'b0, we: (we && sz == SZ_WORD), a: idx,
            wd: (we && sz == SZ_WORD) ? wd : 32'h0, rdata: 32'h0, err: 1'b0};
      exp_q.push_back(e);
      lat = 1;
      if (we && sz == SZ_WORD) begin
        ref_mem[idx[5:0]] = wd;
      end else if (we) begin
        merged = m_merge(ref_mem[idx[5:0]], wd, addr[1:0], sz);
        e = '{rdy: 1'b0, rv: 1'b0, we: 1'b1, a: idx, wd: merged, rdata: 32'h0, err: 1'b0};
        exp_q.push_back(e);
        ref_mem[idx[5:0]] = merged;
        lat = 2;
      end else begin
        rdata = m_extract(ref_mem[idx[5:0]], addr[1:0], sz, sg);
      end
    end
    e = '{rdy: 1'b0, rv: 1'b1, we: 1'b0, a: last_mem_a, wd: 32'h0, rdata: rdata, err: err};
    repeat (bp + 1) exp_q.push_back(e);

    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_size   = 2'($urandom_range(0, 3));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.resp_ready = (bp == 0);
    repeat (lat + bp) @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_during_write();
    cmp_en = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = SZ_BYTE;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h23;
    bus.req_wdata  = 32'h0000_005A;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_access_state", 32'(dbg_state), 32'(ACCESS));
    chk("rst_access_we",    32'(bus.mem_we), 32'd0);
    @(negedge clk);
    chk("rst_write_state",  32'(dbg_state), 32'(WRITE));
    chk("rst_write_we",     32'(bus.mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_mem_a",      bus.mem_a,           32'd0);
    chk("rst_mem_wd",     bus.mem_wd,          32'd0);
    @(posedge clk);
    #1;
    chk("rst_mem_unchanged", mem[8], ref_mem[8]);
    chk("rst_state_idle", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    last_mem_a = 32'h0;
    cmp_en = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    int          r, bp;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;
    cmp_en     = 0;
    last_mem_a = 32'h0;
    last_rdata = 32'h0;
    last_err   = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

    #1 reset = 1'b1;
    #2;
    chk("reset_req_ready",  32'(bus.req_ready),  32'd1);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset_resp_rdata", bus.resp_rdata,      32'd0);
    chk("reset_resp_err",   32'(bus.resp_err),   32'd0);
    chk("reset_mem_a",      bus.mem_a,           32'd0);
    chk("reset_mem_we",     32'(bus.mem_we),     32'd0);
    chk("reset_mem_wd",     bus.mem_wd,          32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1;

    for (int i = 0; i < 64; i++) do_txn(1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom, 0);

    do_txn(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    chk("sw_mem4", mem[4], 32'hDEAD_BEEF);
    chk("sw_err", 32'(last_err), 32'd0);
    do_txn(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0);
    chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);

    do_txn(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8180_7F01, 0);
    do_txn(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 0);
    chk("lb_signed_13", last_rdata, 32'hFFFF_FF81);
    do_txn(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 0);
    chk("lbu_13", last_rdata, 32'h0000_0081);
    do_txn(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 0);
    chk("lb_signed_11", last_rdata, 32'h0000_007F);
    do_txn(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 0);
    chk("lh_signed_12", last_rdata, 32'hFFFF_8180);

    do_txn(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, 0);
    do_txn(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h5555_ABCD, 0);
    chk("sh_mem4", mem[4], 32'hABCD_3344);
    chk("sh_model4", ref_mem[4], 32'hABCD_3344);
    do_txn(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h1234_56EE, 0);
    chk("sb_mem4", mem[4], 32'hABCD_33EE);
    chk("sb_model4", ref_mem[4], 32'hABCD_33EE);

    do_txn(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 0);
    chk("err_half_11", {last_rdata[30:0], last_err}, 32'h1);
    do_txn(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 0);
    chk("err_word_12", {last_rdata[30:0], last_err}, 32'h1);
    do_txn(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hFFFF_FFFF, 0);
    chk("err_word_100", {last_rdata[30:0], last_err}, 32'h1);
    do_txn(1'b1, 2'b11, 1'b0, 32'h8, 32'hFFFF_FFFF, 0);
    chk("err_size_11", {last_rdata[30:0], last_err}, 32'h1);

    do_txn(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5);
    chk("bp_rdata", last_rdata, 32'hABCD_33EE);
    do_txn(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0000_0077, 5);

    reset_during_write();

    repeat (300) begin
      r  = $urandom_range(0, 15);
      sz = (r < 5) ? SZ_BYTE : (r < 10) ? SZ_HALF : (r < 15) ? SZ_WORD : 2'b11;
      addr = 32'($urandom_range(0, 67) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      bp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, bp);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
